// File: rtl/xor_acc_pkg.sv
// Shared types and helpers for the XOR frame accumulator.
package xor_acc_pkg;

  // Frame state: no frame open, frame open, result presented.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Count width able to represent 0..max_words inclusive.
  function automatic int calc_cw(input int max_words);
    return $clog2(max_words + 1);
  endfunction

endpackage

// File: rtl/xor_frame_accumulator.sv
// XOR-folds a frame of words received over valid/ready and presents the
// folded result with parity, saturating beat count and overflow flag.
module xor_frame_accumulator
  import xor_acc_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_WORDS = 16,
  parameter bit INVERT    = 1'b0,
  localparam int CW       = calc_cw(MAX_WORDS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_xor,
  output logic             m_parity,
  output logic [CW-1:0]    m_count,
  output logic             m_overflow
);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WORDS);
  localparam logic [CW-1:0] ONE_CNT = CW'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  // Next-state and datapath update; registers hold unless a beat or handshake occurs.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (s_valid) begin
          acc_d   = s_data;
          cnt_d   = ONE_CNT;
          ovf_d   = 1'b0;
          state_d = s_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (s_valid) begin
          // Words past the limit still fold into the result; only the count saturates.
          acc_d = acc_q ^ s_data;
          if (cnt_q == MAX_CNT) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + ONE_CNT;
          end
          state_d = s_last ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        // Result registers are left untouched; the next first beat overwrites them.
        if (m_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake outputs decode the state register only, so no input reaches them combinationally.
  assign s_ready    = (state_q != HOLD);
  assign m_valid    = (state_q == HOLD);
  assign m_xor      = acc_q ^ {WIDTH{INVERT}};
  assign m_parity   = ^m_xor;
  assign m_count    = cnt_q;
  assign m_overflow = ovf_q;

endmodule

// File: tb/tb_xor_frame_accumulator.sv
// Directed bench: four accumulator configurations sharing one clock and reset.
// inst0: WIDTH=1, inst1: WIDTH=8, inst2: WIDTH=8 INVERT=1, inst3: MAX_WORDS=4.
module tb_xor_frame_accumulator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       sv [4];
  logic       sl [4];
  logic       mr [4];
  logic [7:0] sd [4];

  logic       sr0, sr1, sr2, sr3;
  logic       mv0, mv1, mv2, mv3;
  logic       mp0, mp1, mp2, mp3;
  logic [0:0] mx0;
  logic [7:0] mx1, mx2, mx3;
  logic [4:0] mc0, mc1, mc2;
  logic [2:0] mc3;
  logic       mo0, mo1, mo2, mo3;

  int checks = 0;
  int errors = 0;

  xor_frame_accumulator #(.WIDTH(1), .MAX_WORDS(16), .INVERT(1'b0)) u_w1 (
    .clk(clk), .rst_n(rst_n), .s_valid(sv[0]), .s_ready(sr0), .s_data(sd[0][0:0]),
    .s_last(sl[0]), .m_valid(mv0), .m_ready(mr[0]), .m_xor(mx0), .m_parity(mp0),
    .m_count(mc0), .m_overflow(mo0));

  xor_frame_accumulator #(.WIDTH(8), .MAX_WORDS(16), .INVERT(1'b0)) u_main (
    .clk(clk), .rst_n(rst_n), .s_valid(sv[1]), .s_ready(sr1), .s_data(sd[1]),
    .s_last(sl[1]), .m_valid(mv1), .m_ready(mr[1]), .m_xor(mx1), .m_parity(mp1),
    .m_count(mc1), .m_overflow(mo1));

  xor_frame_accumulator #(.WIDTH(8), .MAX_WORDS(16), .INVERT(1'b1)) u_inv (
    .clk(clk), .rst_n(rst_n), .s_valid(sv[2]), .s_ready(sr2), .s_data(sd[2]),
    .s_last(sl[2]), .m_valid(mv2), .m_ready(mr[2]), .m_xor(mx2), .m_parity(mp2),
    .m_count(mc2), .m_overflow(mo2));

  xor_frame_accumulator #(.WIDTH(8), .MAX_WORDS(4), .INVERT(1'b0)) u_m4 (
    .clk(clk), .rst_n(rst_n), .s_valid(sv[3]), .s_ready(sr3), .s_data(sd[3]),
    .s_last(sl[3]), .m_valid(mv3), .m_ready(mr[3]), .m_xor(mx3), .m_parity(mp3),
    .m_count(mc3), .m_overflow(mo3));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic beat(input int i, input logic [7:0] d, input logic l);
    sv[i] = 1'b1;
    sd[i] = d;
    sl[i] = l;
    tick();
    sv[i] = 1'b0;
    sl[i] = 1'b0;
  endtask

  task automatic pop(input int i);
    mr[i] = 1'b1;
    tick();
    mr[i] = 1'b0;
  endtask

  logic [1:0] w1_pairs [4];
  logic [0:0] w1_exp   [4];

  initial begin
    for (int i = 0; i < 4; i++) begin
      sv[i] = 1'b0; sl[i] = 1'b0; mr[i] = 1'b0; sd[i] = 8'h00;
    end
    w1_pairs[0] = 2'b00; w1_exp[0] = 1'b0;
    w1_pairs[1] = 2'b01; w1_exp[1] = 1'b1;
    w1_pairs[2] = 2'b10; w1_exp[2] = 1'b1;
    w1_pairs[3] = 2'b11; w1_exp[3] = 1'b0;

    tick();
    tick();
    // Reset state, observed while reset is still asserted and after release.
    check_eq("rst_sready1", sr1, 1);
    check_eq("rst_mvalid1", mv1, 0);
    rst_n = 1'b1;
    tick();
    check_eq("rst_mxor1", mx1, 8'h00);
    check_eq("rst_mcount1", mc1, 0);
    check_eq("rst_movf1", mo1, 0);
    check_eq("rst_mxor_inv", mx2, 8'hFF);
    check_eq("rst_mpar_inv", mp2, 0);
    check_eq("rst_mvalid_inv", mv2, 0);
    check_eq("rst_mcount_m4", mc3, 0);
    check_eq("rst_sready_w1", sr0, 1);

    // WIDTH=1 truth table as 2-word frames.
    for (int k = 0; k < 4; k++) begin
      beat(0, {7'd0, w1_pairs[k][1]}, 1'b0);
      beat(0, {7'd0, w1_pairs[k][0]}, 1'b1);
      check_eq($sformatf("w1_valid_%0d", k), mv0, 1);
      check_eq($sformatf("w1_xor_%0d", k), mx0, w1_exp[k]);
      check_eq($sformatf("w1_par_%0d", k), mp0, w1_exp[k]);
      check_eq($sformatf("w1_cnt_%0d", k), mc0, 2);
      check_eq($sformatf("w1_ovf_%0d", k), mo0, 0);
      $display("w1 frame %b -> xor=%b count=%0d", w1_pairs[k], mx0, mc0);
      pop(0);
      check_eq($sformatf("w1_idle_%0d", k), mv0, 0);
    end

    // WIDTH=8 three-word frame and latency.
    beat(1, 8'hA5, 1'b0);
    beat(1, 8'h3C, 1'b0);
    check_eq("main_valid_before_last", mv1, 0);
    beat(1, 8'hFF, 1'b1);
    check_eq("main_valid_after_last", mv1, 1);
    check_eq("main_xor", mx1, 8'h66);
    check_eq("main_par", mp1, 0);
    check_eq("main_cnt", mc1, 3);
    check_eq("main_ovf", mo1, 0);
    $display("main frame A5,3C,FF -> xor=%h count=%0d", mx1, mc1);
    pop(1);
    check_eq("main_back_idle", mv1, 0);

    // m_ready while idle does nothing.
    pop(1);
    check_eq("main_mready_idle_sready", sr1, 1);
    check_eq("main_mready_idle_mvalid", mv1, 0);

    // XNOR mode single-word frames.
    beat(2, 8'h0F, 1'b1);
    check_eq("inv_valid", mv2, 1);
    check_eq("inv_xor", mx2, 8'hF0);
    check_eq("inv_par", mp2, 0);
    check_eq("inv_cnt", mc2, 1);
    $display("inv frame 0F -> xor=%h count=%0d", mx2, mc2);
    pop(2);
    beat(2, 8'h01, 1'b1);
    check_eq("inv_xor2", mx2, 8'hFE);
    check_eq("inv_par2", mp2, 1);
    $display("inv frame 01 -> xor=%h count=%0d", mx2, mc2);
    pop(2);

    // MAX_WORDS=4: exactly four words, no overflow.
    for (int k = 1; k <= 4; k++) beat(3, 8'(k), k == 4);
    check_eq("m4_exact_xor", mx3, 8'h04);
    check_eq("m4_exact_cnt", mc3, 4);
    check_eq("m4_exact_ovf", mo3, 0);
    $display("m4 frame 01..04 -> xor=%h count=%0d ovf=%b", mx3, mc3, mo3);
    pop(3);
    // Six words of 0x01: count saturates, overflow set, all words folded.
    for (int k = 1; k <= 6; k++) beat(3, 8'h01, k == 6);
    check_eq("m4_ovf_xor", mx3, 8'h00);
    check_eq("m4_ovf_cnt", mc3, 4);
    check_eq("m4_ovf_flag", mo3, 1);
    $display("m4 frame 6x01 -> xor=%h count=%0d ovf=%b", mx3, mc3, mo3);
    pop(3);
    beat(3, 8'h02, 1'b1);
    check_eq("m4_next_ovf", mo3, 0);
    check_eq("m4_next_cnt", mc3, 1);
    check_eq("m4_next_xor", mx3, 8'h02);
    $display("m4 frame 02 -> xor=%h count=%0d ovf=%b", mx3, mc3, mo3);
    pop(3);

    // Back-pressure: result held while a new word waits.
    beat(1, 8'h11, 1'b0);
    beat(1, 8'h22, 1'b1);
    sv[1] = 1'b1; sd[1] = 8'h77; sl[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check_eq($sformatf("bp_sready_%0d", k), sr1, 0);
      check_eq($sformatf("bp_mvalid_%0d", k), mv1, 1);
      check_eq($sformatf("bp_xor_%0d", k), mx1, 8'h33);
      check_eq($sformatf("bp_cnt_%0d", k), mc1, 2);
      tick();
    end
    $display("bp frame 11,22 -> xor=%h count=%0d", mx1, mc1);
    mr[1] = 1'b1;
    tick();
    mr[1] = 1'b0;
    check_eq("bp_release_sready", sr1, 1);
    check_eq("bp_release_mvalid", mv1, 0);
    tick();
    sv[1] = 1'b0; sl[1] = 1'b0;
    check_eq("bp_pending_valid", mv1, 1);
    check_eq("bp_pending_xor", mx1, 8'h77);
    check_eq("bp_pending_cnt", mc1, 1);
    $display("bp frame 77 -> xor=%h count=%0d", mx1, mc1);
    pop(1);

    // Reset in the middle of a frame discards it.
    beat(1, 8'h12, 1'b0);
    beat(1, 8'h34, 1'b0);
    rst_n = 1'b0;
    tick();
    check_eq("rst_mid_mvalid", mv1, 0);
    check_eq("rst_mid_sready", sr1, 1);
    check_eq("rst_mid_cnt", mc1, 0);
    check_eq("rst_mid_xor", mx1, 8'h00);
    rst_n = 1'b1;
    tick();
    check_eq("rst_mid_still_idle", mv1, 0);
    beat(1, 8'h55, 1'b1);
    check_eq("post_rst_valid", mv1, 1);
    check_eq("post_rst_xor", mx1, 8'h55);
    check_eq("post_rst_cnt", mc1, 1);
    $display("post-reset frame 55 -> xor=%h count=%0d", mx1, mc1);
    pop(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xor_frame_accumulator.md
# xor_frame_accumulator

Streaming, parametrised successor to the two-input XOR gate: accepts a frame of WIDTH-bit words over a valid/ready interface, XOR-folds every word of the frame into one WIDTH-bit result, and presents that result with reduction parity, beat count and an overflow flag on an output handshake. It sits between a word source and a checker or consumer, and serves as the team's reference for clocked, handshaked blocks with self-checking benches.

## Interface
- WIDTH, 8, data word width in bits (>=1)
- MAX_WORDS, 16, largest frame length counted exactly; CW = $clog2(MAX_WORDS+1)
- INVERT, 0, 1 = XNOR mode (m_xor and m_parity inverted on output)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- s_valid  in  1  input word valid
- s_ready  out  1  block can accept a word
- s_data  in  WIDTH  input word
- s_last  in  1  final word of frame
- m_valid  out  1  result valid
- m_ready  in  1  consumer accepts result
- m_xor  out  WIDTH  bitwise XOR of all frame words (inverted if INVERT)
- m_parity  out  1  ^m_xor (computed after inversion)
- m_count  out  CW  words in frame, saturating at MAX_WORDS
- m_overflow  out  1  frame exceeded MAX_WORDS words

## Operation
- States: IDLE (no frame open), ACCUM (frame open), HOLD (result presented).
- s_ready = 1 in IDLE and ACCUM, 0 in HOLD. m_valid = 1 only in HOLD.
- Input beat accepted when s_valid && s_ready.
- IDLE + beat: acc <= s_data, cnt <= 1, ovf <= 0; next = HOLD if s_last else ACCUM.
- ACCUM + beat: acc <= acc ^ s_data; cnt <= cnt+1 saturating at MAX_WORDS; ovf <= 1 (sticky) if cnt == MAX_WORDS before the beat; next = HOLD if s_last else ACCUM.
- No beat: state and registers hold.
- HOLD: outputs stable while m_valid && !m_ready; s_valid/s_data/s_last ignored. On m_ready: next = IDLE; acc, cnt, ovf unchanged until the next first beat overwrites them.
- Words beyond MAX_WORDS are still XORed into acc; only count saturates.
- Single-word frame (s_last on first beat) is legal: result = that word, count 1.
- m_xor = acc ^ {WIDTH{INVERT}}; m_parity = ^m_xor; m_count = cnt; m_overflow = ovf.

## Timing
- Reset (async assert, sync release via clk edge): state IDLE, acc 0, cnt 0, ovf 0; therefore s_ready 1, m_valid 0, m_xor = {WIDTH{INVERT}}, m_parity = ^{WIDTH{INVERT}}, m_count 0, m_overflow 0.
- Latency: m_valid rises the cycle after the s_last beat is accepted.
- Throughput: one word per cycle within a frame; minimum one-cycle HOLD plus return to IDLE between frames, so next frame's first beat can be accepted the cycle after the m_ready handshake.
- No combinational path from m_ready to s_ready, or from s_valid to m_valid.
- Reset mid-frame or mid-HOLD discards the frame; no result is emitted for it.
- m_ready asserted outside HOLD has no effect.

## Structure
- Package xor_acc_pkg: state enum (IDLE, ACCUM, HOLD) as 2-bit typedef; helper function for CW.
- Single module; no sub-module is natural — datapath is one register, a counter and a flag.

## Test plan
- WIDTH=1, INVERT=0, four 2-word frames {0,0},{0,1},{1,0},{1,1} -> m_xor 0,1,1,0; m_count 2; m_overflow 0.
- WIDTH=8 frame 0xA5,0x3C,0xFF (last) -> m_xor 0x66, m_parity 0, m_count 3, m_valid one cycle after last beat.
- INVERT=1, single word 0x0F with s_last -> m_xor 0xF0, m_parity 0, m_count 1.
- MAX_WORDS=4, six words of 0x01 -> m_xor 0x00, m_count 4, m_overflow 1; next frame 0x02 (last) -> m_overflow 0, m_count 1.
- Hold m_ready low 5 cycles with s_valid high -> s_ready 0, outputs stable, no beat consumed; m_ready high -> IDLE next cycle, pending word accepted as first of new frame.
- Assert rst_n low after two beats of a frame -> m_valid stays 0, s_ready 1, m_count 0; following 1-word frame 0x55 reports 0x55, count 1.
